// File: rtl/vector_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vector_addr_gen_pkg
// Brief   : Shared types and default sizing for the CIM address generator.
// Revision: 1.0 - initial release
// ============================================================================
package vector_addr_gen_pkg;

    localparam int c_NUM_BANKS = 4;
    localparam int c_BANK_SIZE = 14336;
    localparam int c_MAX_LEN   = 64;
    localparam int c_ADDR_W    = $clog2(c_NUM_BANKS * c_BANK_SIZE);
    localparam int c_LEN_W     = $clog2(c_MAX_LEN + 1);
    localparam int c_BANK_W    = $clog2(c_NUM_BANKS);
    localparam int c_OFF_W     = $clog2(c_BANK_SIZE);

    typedef logic [c_ADDR_W-1:0] FlatAddr_t;
    typedef logic [c_LEN_W-1:0]  VectorLen_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic {
        FIRST_HALF  = 1'b0,
        SECOND_HALF = 1'b1
    } HalfSelect_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } AddrGenState_t;

endpackage
`default_nettype wire

// File: rtl/vector_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vector_addr_gen_if
// Brief   : Handshaked beat stream from the address generator to the banks.
// Revision: 1.0 - initial release
// ============================================================================
interface vector_addr_gen_if
    import vector_addr_gen_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int BANK_W = c_BANK_W,
    parameter int OFF_W  = c_OFF_W
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_flat;
    logic [BANK_W-1:0] out_bank;
    logic [OFF_W-1:0]  out_bank_addr;
    HalfSelect_t       out_half;
    logic              out_last;

    modport master (
        output out_valid, out_flat, out_bank, out_bank_addr, out_half, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_flat, out_bank, out_bank_addr, out_half, out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/vector_addr_gen_bank_decoder.sv
`default_nettype none
// ============================================================================
// Module  : vector_addr_gen_bank_decoder
// Brief   : Comparator chain mapping a flat word address to (bank, offset).
// Revision: 1.0 - initial release
// ============================================================================
module vector_addr_gen_bank_decoder
    import vector_addr_gen_pkg::*;
#(
    parameter int NUM_BANKS = c_NUM_BANKS,
    parameter int BANK_SIZE = c_BANK_SIZE,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int BANK_W    = c_BANK_W,
    parameter int OFF_W     = c_OFF_W
) (
    input  logic [ADDR_W-1:0] flat_i,
    output logic [BANK_W-1:0] bank_o,
    output logic [OFF_W-1:0]  offset_o
);
    // Later banks override earlier ones, leaving the largest b with b*BANK_SIZE <= flat.
    always_comb begin
        bank_o   = '0;
        offset_o = flat_i[OFF_W-1:0];
        for (int b = 1; b < NUM_BANKS; b++) begin
            if (flat_i >= ADDR_W'(b * BANK_SIZE)) begin
                bank_o   = BANK_W'(b);
                offset_o = OFF_W'(flat_i - ADDR_W'(b * BANK_SIZE));
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vector_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : vector_addr_gen
// Brief   : Strided 1-D/2-D bank-decoded address stream for the CIM banks.
// Revision: 1.0 - initial release
// ============================================================================
module vector_addr_gen
    import vector_addr_gen_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_SIZE = 14336,
    parameter int MAX_LEN   = 64,
    parameter int ADDR_W    = $clog2(NUM_BANKS * BANK_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] len_i,
    input  logic [ADDR_W-1:0]            stride_in_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] outer_cnt_i,
    input  logic [ADDR_W-1:0]            stride_out_i,
    input  DataWidth_t                   width_i,
    vector_addr_gen_if.master            beat_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_oob_o
);
    localparam int c_LEN_W  = $clog2(MAX_LEN + 1);
    localparam int c_BANK_W = $clog2(NUM_BANKS);
    localparam int c_OFF_W  = $clog2(BANK_SIZE);
    // Two guard bits so an in-range address plus a doubled stride cannot wrap.
    localparam int c_CALC_W = ADDR_W + 2;
    localparam logic [c_CALC_W-1:0] c_LIMIT   = c_CALC_W'(NUM_BANKS * BANK_SIZE);
    localparam logic [c_LEN_W-1:0]  c_LEN_ONE = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0]  c_LEN_TWO = c_LEN_W'(2);

    AddrGenState_t       state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d, elem_q, elem_d, ostride_q, ostride_d;
    logic [ADDR_W:0]     estride_q, estride_d;
    logic [c_LEN_W-1:0]  len_q, len_d, outer_q, outer_d, k_q, k_d, r_q, r_d;
    DataWidth_t          width_q, width_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d, last_q, last_d;
    logic [ADDR_W-1:0]   flat_q, flat_d;
    logic [c_BANK_W-1:0] bank_q, bank_d;
    logic [c_OFF_W-1:0]  off_q, off_d;
    HalfSelect_t         half_q, half_d;

    logic                w_load, w_last, w_k_end, w_r_end;
    logic [c_CALC_W-1:0] w_addr;
    logic [ADDR_W-1:0]   w_row, w_elem;
    logic [c_LEN_W-1:0]  w_k, w_r;
    HalfSelect_t         w_half;
    logic [c_BANK_W-1:0] w_dec_bank;
    logic [c_OFF_W-1:0]  w_dec_off;

    vector_addr_gen_bank_decoder #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_SIZE (BANK_SIZE),
        .ADDR_W    (ADDR_W),
        .BANK_W    (c_BANK_W),
        .OFF_W     (c_OFF_W)
    ) u_bank_decoder (
        .flat_i   (w_addr[ADDR_W-1:0]),
        .bank_o   (w_dec_bank),
        .offset_o (w_dec_off)
    );

    assign w_k_end = (k_q + c_LEN_ONE) == len_q;
    assign w_r_end = (r_q + c_LEN_ONE) == outer_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        elem_d    = elem_q;
        estride_d = estride_q;
        ostride_d = ostride_q;
        len_d     = len_q;
        outer_d   = outer_q;
        k_d       = k_q;
        r_d       = r_q;
        width_d   = width_q;
        err_d     = err_q;
        valid_d   = valid_q;
        last_d    = last_q;
        flat_d    = flat_q;
        bank_d    = bank_q;
        off_d     = off_q;
        half_d    = half_q;
        w_load    = 1'b0;
        w_addr    = '0;
        w_row     = row_q;
        w_elem    = elem_q;
        w_k       = k_q;
        w_r       = r_q;
        w_half    = FIRST_HALF;
        w_last    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d     = 1'b0;
                    len_d     = len_i;
                    outer_d   = outer_cnt_i;
                    width_d   = width_i;
                    ostride_d = stride_out_i;
                    estride_d = (width_i == DOUBLE_WIDTH) ? {stride_in_i, 1'b0}
                                                          : {1'b0, stride_in_i};
                    if (len_i == '0 || outer_cnt_i == '0) begin
                        state_d = DONE;
                    end else begin
                        w_load = 1'b1;
                        w_addr = c_CALC_W'(base_addr_i);
                        w_row  = base_addr_i;
                        w_elem = base_addr_i;
                        w_k    = '0;
                        w_r    = '0;
                        w_last = (len_i == c_LEN_ONE) && (outer_cnt_i == c_LEN_ONE)
                                 && (width_i == SINGLE_WIDTH);
                    end
                end
            end
            RUN: begin
                if (valid_q && beat_o.out_ready) begin
                    if (width_q == DOUBLE_WIDTH && half_q == FIRST_HALF) begin
                        w_load = 1'b1;
                        w_addr = c_CALC_W'(elem_q) + c_CALC_W'(1);
                        w_half = SECOND_HALF;
                        w_last = w_k_end && w_r_end;
                    end else if (!w_k_end) begin
                        w_load = 1'b1;
                        w_addr = c_CALC_W'(elem_q) + c_CALC_W'(estride_q);
                        w_elem = w_addr[ADDR_W-1:0];
                        w_k    = k_q + c_LEN_ONE;
                        w_last = (width_q == SINGLE_WIDTH) && w_r_end
                                 && ((k_q + c_LEN_TWO) == len_q);
                    end else if (!w_r_end) begin
                        w_load = 1'b1;
                        w_addr = c_CALC_W'(row_q) + c_CALC_W'(ostride_q);
                        w_row  = w_addr[ADDR_W-1:0];
                        w_elem = w_addr[ADDR_W-1:0];
                        w_k    = '0;
                        w_r    = r_q + c_LEN_ONE;
                        w_last = (width_q == SINGLE_WIDTH) && (len_q == c_LEN_ONE)
                                 && ((r_q + c_LEN_TWO) == outer_q);
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Out-of-range beats are never presented; the sequence aborts instead.
        if (w_load) begin
            if (w_addr >= c_LIMIT) begin
                err_d   = 1'b1;
                state_d = DONE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                state_d = RUN;
                valid_d = 1'b1;
                flat_d  = w_addr[ADDR_W-1:0];
                bank_d  = w_dec_bank;
                off_d   = w_dec_off;
                half_d  = w_half;
                last_d  = w_last;
                row_d   = w_row;
                elem_d  = w_elem;
                k_d     = w_k;
                r_d     = w_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            elem_q    <= '0;
            estride_q <= '0;
            ostride_q <= '0;
            len_q     <= '0;
            outer_q   <= '0;
            k_q       <= '0;
            r_q       <= '0;
            width_q   <= SINGLE_WIDTH;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            flat_q    <= '0;
            bank_q    <= '0;
            off_q     <= '0;
            half_q    <= FIRST_HALF;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            elem_q    <= elem_d;
            estride_q <= estride_d;
            ostride_q <= ostride_d;
            len_q     <= len_d;
            outer_q   <= outer_d;
            k_q       <= k_d;
            r_q       <= r_d;
            width_q   <= width_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            flat_q    <= flat_d;
            bank_q    <= bank_d;
            off_q     <= off_d;
            half_q    <= half_d;
        end
    end

    assign beat_o.out_valid     = valid_q;
    assign beat_o.out_flat      = flat_q;
    assign beat_o.out_bank      = bank_q;
    assign beat_o.out_bank_addr = off_q;
    assign beat_o.out_half      = half_q;
    assign beat_o.out_last      = last_q;
    assign busy_o               = (state_q != IDLE);
    assign done_o               = (state_q == DONE);
    assign err_oob_o            = err_q;
endmodule
`default_nettype wire

// File: tb/tb_vector_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_addr_gen
// Brief   : Directed self-checking bench for vector_addr_gen.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vector_addr_gen;
    import vector_addr_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base, stride_in, stride_out;
    VectorLen_t  len, outer;
    DataWidth_t  width;
    logic        busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    int cap_flat[$];
    int cap_bank[$];
    int cap_off[$];
    int cap_half[$];
    int cap_last[$];

    always #5 clk = ~clk;

    vector_addr_gen_if #(.ADDR_W(16), .BANK_W(2), .OFF_W(14)) beat_if ();

    vector_addr_gen #(
        .NUM_BANKS (4),
        .BANK_SIZE (14336),
        .MAX_LEN   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .base_addr_i  (base),
        .len_i        (len),
        .stride_in_i  (stride_in),
        .outer_cnt_i  (outer),
        .stride_out_i (stride_out),
        .width_i      (width),
        .beat_o       (beat_if.master),
        .busy_o       (busy),
        .done_o       (done),
        .err_oob_o    (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic do_start(input logic [15:0] b, input VectorLen_t l, input logic [15:0] si,
                            input VectorLen_t o, input logic [15:0] so, input DataWidth_t w);
        cap_flat.delete(); cap_bank.delete(); cap_off.delete();
        cap_half.delete(); cap_last.delete();
        base = b; len = l; stride_in = si; outer = o; stride_out = so; width = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records accepted beats until done; stalls 3 cycles on beat index stall_at.
    task automatic collect(input int budget, input int stall_at, output bit saw_done);
        int   beats;
        bit   stalled, prev_last;
        logic [15:0] sf;
        logic [1:0]  sb;
        logic [13:0] so;
        logic        sh, sl;
        beats = 0; stalled = 1'b0; prev_last = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (prev_last) chk("done_after_last", done, 1);
            prev_last = 1'b0;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (beat_if.out_valid && beats == stall_at && !stalled) begin
                stalled = 1'b1;
                beat_if.out_ready = 1'b0;
                sf = beat_if.out_flat; sb = beat_if.out_bank; so = beat_if.out_bank_addr;
                sh = beat_if.out_half; sl = beat_if.out_last;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bp_valid", beat_if.out_valid, 1);
                    chk("bp_flat", beat_if.out_flat, sf);
                    chk("bp_bank", beat_if.out_bank, sb);
                    chk("bp_off", beat_if.out_bank_addr, so);
                    chk("bp_half", beat_if.out_half, sh);
                    chk("bp_last", beat_if.out_last, sl);
                end
                beat_if.out_ready = 1'b1;
            end
            if (beat_if.out_valid) begin
                cap_flat.push_back(int'(beat_if.out_flat));
                cap_bank.push_back(int'(beat_if.out_bank));
                cap_off.push_back(int'(beat_if.out_bank_addr));
                cap_half.push_back(int'(beat_if.out_half));
                cap_last.push_back(int'(beat_if.out_last));
                prev_last = beat_if.out_last;
                beats++;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_beat(input int i, input int f, input int b, input int o,
                               input int h, input int l);
        if (i < cap_flat.size()) begin
            chk($sformatf("flat[%0d]", i), cap_flat[i], f);
            chk($sformatf("bank[%0d]", i), cap_bank[i], b);
            chk($sformatf("off[%0d]", i), cap_off[i], o);
            chk($sformatf("half[%0d]", i), cap_half[i], h);
            chk($sformatf("last[%0d]", i), cap_last[i], l);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit fin;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; stride_in = '0;
        outer = '0; stride_out = '0; width = SINGLE_WIDTH;
        beat_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", beat_if.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_flat", beat_if.out_flat, 0);
        chk("rst_last", beat_if.out_last, 0);
        chk("rst_half", beat_if.out_half, 0);

        // Bank crossing, single width
        do_start(16'd14335, 7'd3, 16'd1, 7'd1, 16'd0, SINGLE_WIDTH);
        chk("first_valid_latency", beat_if.out_valid, 1);
        chk("busy_running", busy, 1);
        collect(50, -1, fin);
        chk("xbank_done", fin, 1);
        chk("xbank_nbeats", cap_flat.size(), 3);
        expect_beat(0, 14335, 0, 14335, 0, 0);
        expect_beat(1, 14336, 1, 0, 0, 0);
        expect_beat(2, 14337, 1, 1, 0, 1);
        chk("xbank_busy_at_done", busy, 1);
        @(negedge clk);
        chk("xbank_busy_after", busy, 0);
        chk("xbank_done_pulse", done, 0);

        // Double width
        do_start(16'd0, 7'd2, 16'd1, 7'd1, 16'd0, DOUBLE_WIDTH);
        collect(50, -1, fin);
        chk("dbl_done", fin, 1);
        chk("dbl_nbeats", cap_flat.size(), 4);
        expect_beat(0, 0, 0, 0, 0, 0);
        expect_beat(1, 1, 0, 1, 1, 0);
        expect_beat(2, 2, 0, 2, 0, 0);
        expect_beat(3, 3, 0, 3, 1, 1);
        @(negedge clk);

        // 2-D traversal
        do_start(16'd100, 7'd2, 16'd1, 7'd2, 16'd64, SINGLE_WIDTH);
        collect(50, -1, fin);
        chk("2d_done", fin, 1);
        chk("2d_nbeats", cap_flat.size(), 4);
        expect_beat(0, 100, 0, 100, 0, 0);
        expect_beat(1, 101, 0, 101, 0, 0);
        expect_beat(2, 164, 0, 164, 0, 0);
        expect_beat(3, 165, 0, 165, 0, 1);
        @(negedge clk);

        // Same 2-D sweep with backpressure on beat 2
        do_start(16'd100, 7'd2, 16'd1, 7'd2, 16'd64, SINGLE_WIDTH);
        collect(50, 1, fin);
        chk("bp_seq_done", fin, 1);
        chk("bp_nbeats", cap_flat.size(), 4);
        expect_beat(0, 100, 0, 100, 0, 0);
        expect_beat(1, 101, 0, 101, 0, 0);
        expect_beat(2, 164, 0, 164, 0, 0);
        expect_beat(3, 165, 0, 165, 0, 1);
        @(negedge clk);

        // Out of range abort
        do_start(16'd57343, 7'd3, 16'd1, 7'd1, 16'd0, SINGLE_WIDTH);
        collect(50, -1, fin);
        chk("oob_done", fin, 1);
        chk("oob_nbeats", cap_flat.size(), 1);
        expect_beat(0, 57343, 3, 14335, 0, 0);
        chk("oob_err", err, 1);
        chk("oob_valid", beat_if.out_valid, 0);
        @(negedge clk);
        chk("oob_sticky", err, 1);

        // Zero length: immediate done, clears err
        do_start(16'd10, 7'd0, 16'd1, 7'd1, 16'd0, SINGLE_WIDTH);
        chk("len0_done", done, 1);
        chk("len0_valid", beat_if.out_valid, 0);
        chk("len0_err_clear", err, 0);
        @(negedge clk);
        chk("len0_idle", busy, 0);

        // Reset in the middle of a long sequence
        do_start(16'd0, 7'd64, 16'd1, 7'd1, 16'd0, SINGLE_WIDTH);
        repeat (5) @(negedge clk);
        chk("long_flat5", beat_if.out_flat, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", beat_if.out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_flat", beat_if.out_flat, 0);
        chk("mrst_bank", beat_if.out_bank, 0);
        chk("mrst_off", beat_if.out_bank_addr, 0);
        chk("mrst_last", beat_if.out_last, 0);

        // Fresh start after reset, stride 3
        do_start(16'd200, 7'd2, 16'd3, 7'd1, 16'd0, SINGLE_WIDTH);
        collect(50, -1, fin);
        chk("post_rst_done", fin, 1);
        chk("post_rst_nbeats", cap_flat.size(), 2);
        expect_beat(0, 200, 0, 200, 0, 0);
        expect_beat(1, 203, 0, 203, 0, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
